// File: rtl/score_pkg.sv
// Shared types and constants for the Pong score keeper: BCD digits, game states,
// winner codes and an elaboration-time integer-to-BCD conversion.
package score_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        PLAY = 1'b0,
        WIN  = 1'b1
    } game_state_t;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;
    localparam winner_t WIN_TIE  = 2'b11;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_score_t;

    // Only ever called on parameters, so it folds to a constant.
    function automatic bcd_score_t to_bcd(input int unsigned value);
        bcd_score_t r;
        r.tens = bcd_t'(value / 10);
        r.ones = bcd_t'(value % 10);
        return r;
    endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Bundle between the game logic (point/new_game requests) and the score display
// path (BCD digits, enables, game status).
interface score_display_ctrl_if;
    import score_pkg::*;

    logic       point_p1;
    logic       point_p2;
    logic       new_game;
    bcd_t       p1_tens;
    bcd_t       p1_ones;
    bcd_t       p2_tens;
    bcd_t       p2_ones;
    logic [3:0] digit_en;
    logic       game_over;
    winner_t    winner;

    modport master (
        output point_p1, point_p2, new_game,
        input  p1_tens, p1_ones, p2_tens, p2_ones, digit_en, game_over, winner
    );

    modport slave (
        input  point_p1, point_p2, new_game,
        output p1_tens, p1_ones, p2_tens, p2_ones, digit_en, game_over, winner
    );

endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register for one player. Saturates at WIN_SCORE and exposes
// its next value so the parent can make the win decision in the same cycle.
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output bcd_score_t score,
    output bcd_score_t score_next,
    output logic       at_win
);

    localparam bcd_score_t WIN_BCD = to_bcd(WIN_SCORE);

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        score_next = score;
        if (clr) begin
            score_next = '0;
        end else if (inc && (score != WIN_BCD)) begin
            if (score.ones == 4'd9) begin
                score_next.ones = 4'd0;
                score_next.tens = score.tens + 4'd1;
            end else begin
                score_next.ones = score.ones + 4'd1;
            end
        end
    end

    assign at_win = (score_next == WIN_BCD);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            score <= '0;
        end else begin
            score <= score_next;
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Pong score keeper: point edge detection, PLAY/WIN state machine, winner blink
// prescaler and leading-zero-suppressed digit enables for four 7-segment decoders.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    score_display_ctrl_if.slave  bus
);

    localparam bcd_score_t  WIN_BCD  = to_bcd(WIN_SCORE);
    localparam int unsigned CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    game_state_t      state;
    game_state_t      state_next;
    winner_t          winner_q;
    logic             prev_p1;
    logic             prev_p2;
    logic             hit_p1;
    logic             hit_p2;
    logic             inc_p1;
    logic             inc_p2;
    bcd_score_t       p1_score;
    bcd_score_t       p2_score;
    bcd_score_t       p1_next;
    bcd_score_t       p2_next;
    logic             p1_at_win;
    logic             p2_at_win;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             p1_lit;
    logic             p2_lit;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            prev_p1 <= bus.point_p1;
            prev_p2 <= bus.point_p2;
        end
    end

    assign hit_p1 = bus.point_p1 & ~prev_p1;
    assign hit_p2 = bus.point_p2 & ~prev_p2;

    // new_game wins over any hit on the same cycle.
    assign inc_p1 = (state == PLAY) && hit_p1 && !bus.new_game;
    assign inc_p2 = (state == PLAY) && hit_p2 && !bus.new_game;

    bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p1_score (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc_p1),
        .clr        (bus.new_game),
        .score      (p1_score),
        .score_next (p1_next),
        .at_win     (p1_at_win)
    );

    bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p2_score (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc_p2),
        .clr        (bus.new_game),
        .score      (p2_score),
        .score_next (p2_next),
        .at_win     (p2_at_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PLAY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.new_game) begin
            state_next = PLAY;
        end else if ((state == PLAY) && (p1_at_win || p2_at_win)) begin
            state_next = WIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.new_game) begin
            winner_q <= WIN_NONE;
        end else if ((state == PLAY) && (state_next == WIN)) begin
            case ({p2_next == WIN_BCD, p1_next == WIN_BCD})
                2'b01:   winner_q <= WIN_P1;
                2'b10:   winner_q <= WIN_P2;
                2'b11:   winner_q <= WIN_TIE;
                default: winner_q <= WIN_NONE;
            endcase
        end
    end

    // Blink prescaler idles at count 0 / phase lit outside WIN, so entry starts lit.
    always_ff @(posedge clk) begin
        if (rst || (state != WIN) || bus.new_game) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        // Bit 0 of the winner code flags P1, bit 1 flags P2; a tie sets both.
        p1_lit = !((state == WIN) && winner_q[0]) || blink_phase;
        p2_lit = !((state == WIN) && winner_q[1]) || blink_phase;

        bus.game_over = (state == WIN);
        bus.winner    = winner_q;
        bus.p1_tens   = p1_score.tens;
        bus.p1_ones   = p1_score.ones;
        bus.p2_tens   = p2_score.tens;
        bus.p2_ones   = p2_score.ones;
        bus.digit_en  = {(p1_score.tens != 4'd0) && p1_lit, p1_lit,
                         (p2_score.tens != 4'd0) && p2_lit, p2_lit};
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: an integer score model pushes expected
// outputs into a queue each cycle; they are popped and compared after the edge.
module tb_score_display_ctrl;

    localparam int W_SCORE = 11;
    localparam int B_DIV   = 4;

    typedef struct {
        string      tag;
        logic [3:0] p1t;
        logic [3:0] p1o;
        logic [3:0] p2t;
        logic [3:0] p2o;
        logic [3:0] en;
        logic       go;
        logic [1:0] win;
    } exp_t;

    logic clk;
    logic rst;
    score_display_ctrl_if dif ();

    score_display_ctrl #(.WIN_SCORE(W_SCORE), .BLINK_DIV(B_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model state: plain integers, not BCD.
    int         m_s1 = 0;
    int         m_s2 = 0;
    int         m_wc = 0;
    logic       m_over = 1'b0;
    logic [1:0] m_win = 2'b00;
    logic       m_pa = 1'b0;
    logic       m_pb = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model(input logic a, input logic b, input logic ng, input logic r, input string tag);
        logic ha;
        logic hb;
        logic phase;
        logic l1;
        logic l2;
        exp_t e;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_wc = 0;
            m_over = 1'b0; m_win = 2'b00;
            m_pa = 1'b0; m_pb = 1'b0;
        end else begin
            ha = a & ~m_pa;
            hb = b & ~m_pb;
            m_pa = a;
            m_pb = b;
            if (ng) begin
                m_s1 = 0; m_s2 = 0; m_wc = 0;
                m_over = 1'b0; m_win = 2'b00;
            end else if (!m_over) begin
                if (ha) m_s1++;
                if (hb) m_s2++;
                if (m_s1 == W_SCORE || m_s2 == W_SCORE) begin
                    m_over = 1'b1;
                    m_win  = {m_s2 == W_SCORE, m_s1 == W_SCORE};
                    m_wc   = 0;
                end
            end else begin
                m_wc++;
            end
        end
        phase = !m_over || (((m_wc / B_DIV) % 2) == 0);
        l1 = !(m_over && m_win[0]) || phase;
        l2 = !(m_over && m_win[1]) || phase;
        e.tag = tag;
        e.p1t = 4'(m_s1 / 10);
        e.p1o = 4'(m_s1 % 10);
        e.p2t = 4'(m_s2 / 10);
        e.p2o = 4'(m_s2 % 10);
        e.en  = {(m_s1 >= 10) && l1, l1, (m_s2 >= 10) && l2, l2};
        e.go  = m_over;
        e.win = m_win;
        q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        e = q.pop_front();
        check({e.tag, ".p1_tens"},   {4'd0, dif.p1_tens},  {4'd0, e.p1t});
        check({e.tag, ".p1_ones"},   {4'd0, dif.p1_ones},  {4'd0, e.p1o});
        check({e.tag, ".p2_tens"},   {4'd0, dif.p2_tens},  {4'd0, e.p2t});
        check({e.tag, ".p2_ones"},   {4'd0, dif.p2_ones},  {4'd0, e.p2o});
        check({e.tag, ".digit_en"},  {4'd0, dif.digit_en}, {4'd0, e.en});
        check({e.tag, ".game_over"}, {7'd0, dif.game_over}, {7'd0, e.go});
        check({e.tag, ".winner"},    {6'd0, dif.winner},   {6'd0, e.win});
    endtask

    // Drive at negedge, push the expectation, sample 1 time unit after the edge.
    task automatic step(input logic a, input logic b, input logic ng, input logic r, input string tag);
        @(negedge clk);
        dif.point_p1 = a;
        dif.point_p2 = b;
        dif.new_game = ng;
        rst          = r;
        model(a, b, ng, r, tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        rst          = 1'b1;
        dif.point_p1 = 1'b0;
        dif.point_p2 = 1'b0;
        dif.new_game = 1'b0;

        step(0, 0, 0, 1, "reset0");
        step(0, 0, 0, 1, "reset1");
        step(0, 0, 0, 0, "idle");

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, $sformatf("hold_p1_%0d", i));
        step(0, 0, 0, 0, "release_p1");
        step(0, 0, 1, 0, "new_game0");
        step(0, 0, 1, 0, "new_game1");

        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, $sformatf("p1_edge_%0d", i));
            step(0, 0, 0, 0, $sformatf("p1_low_%0d", i));
        end
        step(1, 0, 0, 0, "p1_win");
        for (int i = 0; i < 16; i++)
            step(1'(i % 2), 1'((i / 2) % 2), 0, 0, $sformatf("p1_blink_%0d", i));

        step(0, 0, 1, 0, "clear_a");
        step(0, 0, 0, 0, "play_a");
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, $sformatf("both_edge_%0d", i));
            step(0, 0, 0, 0, $sformatf("both_low_%0d", i));
        end
        step(1, 1, 0, 0, "tie_win");
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, $sformatf("tie_blink_%0d", i));

        step(0, 0, 1, 0, "clear_b");
        step(0, 1, 1, 0, "ng_with_p2_rise");
        step(0, 1, 0, 0, "p2_still_high");
        step(0, 0, 0, 0, "p2_low");
        for (int i = 0; i < 11; i++) begin
            step(0, 1, 0, 0, $sformatf("p2_edge_%0d", i));
            step(0, 0, 0, 0, $sformatf("p2_low_%0d", i));
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, $sformatf("p2_blink_%0d", i));
        step(1, 0, 0, 1, "rst_mid_blink");
        step(1, 0, 0, 0, "high_after_rst");
        step(1, 0, 0, 0, "held_after_rst");

        check("queue_drained", 8'(q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
